fnd_sum_display: RTL and testbench

- Downstream consumer of the 4-bit ripple-carry adder.
- Captures the adder's 5-bit result {cout, s3..s0} on a load strobe and shows it in decimal on a 4-digit common-anode 7-segment (FND) display.
- Digits are time-multiplexed with a prescaled scan counter.
- Sits between the adder outputs and the board FND pins.

---
 rtl/fnd_sum_display.sv | 96 +++++++++
 tb/tb_fnd_sum_display.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fnd_sum_display.sv
// Latches the 5-bit adder result and shows it in decimal on a 4-digit common-anode FND.
// Build option: define FND_LZB_EN to blank the tens digit when the value is below 10.
module fnd_sum_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  input  logic       load,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  logic [4:0]    val_q;
  logic [PW-1:0] presc;
  logic [1:0]    digit_sel;
  logic          tick;

  logic [1:0]    tens;
  logic [3:0]    ones;
  logic [7:0]    digit_code [4];

  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q     <= '0;
      presc     <= '0;
      digit_sel <= '0;
    end else begin
      if (load) begin
        val_q <= {cout_in, sum_in};
      end
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        digit_sel <= digit_sel + 2'd1;
      end
    end
  end

  // Constant divide on a 5-bit value folds into a small lookup; no multi-cycle BCD needed.
  function automatic logic [5:0] dec_split(input logic [4:0] v);
    int q;
    int r;
    q = int'(v) / 10;
    r = int'(v) % 10;
    return {2'(q), 4'(r)};
  endfunction

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign {tens, ones} = dec_split(val_q);

  assign digit_code[0] = seg_of(ones);
`ifdef FND_LZB_EN
  assign digit_code[1] = (tens == 2'd0) ? SEG_BLANK : seg_of({2'b00, tens});
`else
  assign digit_code[1] = seg_of({2'b00, tens});
`endif
  assign digit_code[2] = SEG_BLANK;
  assign digit_code[3] = val_q[4] ? SEG_DASH : SEG_BLANK;

  // Active-low one-hot-zero digit enables; bit0 drives the rightmost digit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_com
      assign fnd_com[gi] = (digit_sel != 2'(gi));
    end
  endgenerate

  assign fnd_data = digit_code[digit_sel];

endmodule

// File: tb/tb_fnd_sum_display.sv
// Directed bench for fnd_sum_display with a short scan period (SCAN_DIV=4).
module tb_fnd_sum_display;

  logic       clk;
  logic       rst_n;
  logic [3:0] sum_in;
  logic       cout_in;
  logic       load;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int checks   = 0;
  int failures = 0;

  fnd_sum_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sum_in   (sum_in),
    .cout_in  (cout_in),
    .load     (load),
    .fnd_com  (fnd_com),
    .fnd_data (fnd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until digit d is enabled; leaves the caller on a negedge.
  task automatic wait_digit(input int d);
    logic [3:0] pat;
    bit found;
    pat = 4'hF ^ (4'h1 << d);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (fnd_com === pat) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) check_val($sformatf("timeout_digit%0d", d), {4'h0, fnd_com}, {4'h0, pat});
  endtask

  task automatic load_val(input logic c, input logic [3:0] s);
    @(negedge clk);
    cout_in = c;
    sum_in  = s;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load value %0d", {c, s});
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
    wait_digit(0); check_val({tag, "_d0"}, fnd_data, d0);
    wait_digit(1); check_val({tag, "_d1"}, fnd_data, d1);
    wait_digit(2); check_val({tag, "_d2"}, fnd_data, d2);
    wait_digit(3); check_val({tag, "_d3"}, fnd_data, d3);
  endtask

  // Called on the negedge where rst_n is released; checks the scan order and slot length.
  task automatic release_and_step(input string tag);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val({tag, "_com_hold"}, {4'h0, fnd_com}, 8'h0E);
    @(negedge clk);
    check_val({tag, "_com1"}, {4'h0, fnd_com}, 8'h0D);
    repeat (4) @(negedge clk);
    check_val({tag, "_com2"}, {4'h0, fnd_com}, 8'h0B);
    repeat (4) @(negedge clk);
    check_val({tag, "_com3"}, {4'h0, fnd_com}, 8'h07);
    repeat (4) @(negedge clk);
    check_val({tag, "_com0"}, {4'h0, fnd_com}, 8'h0E);
  endtask

  logic [7:0] exp_d1_7;
  logic [7:0] exp_hold;

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    sum_in  = 4'h0;
    cout_in = 1'b0;
`ifdef FND_LZB_EN
    exp_d1_7 = 8'hFF;
`else
    exp_d1_7 = 8'hC0;
`endif

    #3;
    check_val("rst_com", {4'h0, fnd_com}, 8'h0E);
    check_val("rst_data", fnd_data, 8'hC0);
    @(negedge clk);
    @(negedge clk);
    release_and_step("init");

    load_val(1'b1, 4'hF);
    check_frame("v31", 8'hF9, 8'hB0, 8'hFF, 8'hBF);

    // Asynchronous reset in the middle of the digit3 slot.
    wait_digit(3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_com", {4'h0, fnd_com}, 8'h0E);
    check_val("midrst_data", fnd_data, 8'hC0);
    @(negedge clk);
    release_and_step("post");

    load_val(1'b0, 4'h7);
    check_frame("v7", 8'hF8, exp_d1_7, 8'hFF, 8'hFF);

    // Load on the tick edge: presc is 3 on the third negedge of the digit0 slot.
    wait_digit(3);
    wait_digit(0);
    repeat (3) @(negedge clk);
    cout_in = 1'b0;
    sum_in  = 4'hC;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load value 12 on tick");
    check_val("tick_com", {4'h0, fnd_com}, 8'h0D);
    check_val("tick_d1", fnd_data, 8'hF9);
    check_frame("v12", 8'hA4, 8'hF9, 8'hFF, 8'hFF);

    // Back-to-back loads: 5 then 20; last one wins.
    @(negedge clk);
    cout_in = 1'b0; sum_in = 4'h5; load = 1'b1;
    @(negedge clk);
    cout_in = 1'b1; sum_in = 4'h4; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("load values 5 then 20");
    check_frame("v20", 8'hC0, 8'hA4, 8'hFF, 8'hBF);

    // Hold: inputs churn with load low for three frames.
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      sum_in  = 4'(i * 7 + 3);
      cout_in = i[0];
      case (fnd_com)
        4'b1110: exp_hold = 8'hC0;
        4'b1101: exp_hold = 8'hA4;
        4'b1011: exp_hold = 8'hFF;
        4'b0111: exp_hold = 8'hBF;
        default: exp_hold = 8'h00;
      endcase
      check_val($sformatf("hold_%0d", i), fnd_data, exp_hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
